imm_arith_encoder: RTL
======================

Name: imm_arith_encoder

Overview:
- Inverse of the OP-IMM decode path: takes an imm_arith_kind_t plus rd/rs1/immediate and emits RV32I instruction words on a valid/ready stream.
- Used by the boot-ROM/test-program generator and the self-check harness to assemble OP-IMM code into instruction memory.
- Expands li-style requests (addi rd, x0, imm with imm outside 12-bit signed range) into a LUI+ADDI pair via a small FSM.
- Rejects illegal requests with an error pulse.

Parameters:
- CNT_W, 32, width of the emitted-word counter (wraps).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid & in_ready
- in_kind  in  imm_arith_kind_t  operation (iak_addi..iak_andi, iak_invalid)
- in_rd  in  5  destination register
- in_rs1  in  5  source register
- in_imm  in  32  signed immediate / shift amount
- out_valid  out  1  instruction word valid
- out_ready  in  1  sink ready
- out_word  out  32  encoded instruction
- err_valid  out  1  one-cycle pulse: last accepted request rejected
- err_code  out  2  01 invalid kind, 10 imm out of 12-bit range, 11 shamt not in 0..31; held until next error
- words_emitted  out  CNT_W  count of completed out handshakes

Behaviour:
- Reset (rst=1 at posedge): state IDLE, out_valid=0, out_word=0, err_valid=0, err_code=0, words_emitted=0, pending ADDI dropped. Reset wins over any simultaneous handshake.
- Encoding, OP-IMM opcode 0010011:
  - Non-shift: {imm[11:0], rs1, funct3, rd, opcode}.
  - Shifts: {funct7, shamt[4:0], rs1, funct3, rd, opcode}.
  - funct3 values: addi 000, slli 001, slti 010, sltiu 011, xori 100, srli/srai 101, ori 110, andi 111.
  - funct7: 0000000, except srai 0100000.
  - LUI: {hi20, rd, 0110111}.
- Range rules:
  - Non-shift ops: imm must lie in -2048..2047.
  - Shifts: imm must lie in 0..31.
  - Exception: addi with rs1=0 and imm out of range is legal and expands:
    - hi20 = (imm + 0x800) >> 12, mod 2^20.
    - lo12 = imm[11:0].
    - lo12 = 0 emits LUI only.
    - otherwise emits LUI rd,hi20, then ADDI rd,rd,lo12.
  - addi with rs1≠0 and imm out of range: error 10.
- States:
  - IDLE: no pending word.
  - PEND: LUI presented and ADDI still owed.
- in_ready = (state==IDLE) & (~out_valid | out_ready). Deasserted throughout PEND.
- Accepted legal request: out_word/out_valid load on the next posedge (latency 1). A back-to-back accept in the same cycle as an out handshake replaces the word without a bubble.
- Accepted expanding request: LUI is loaded and state goes to PEND. On the LUI handshake, ADDI is loaded the same edge and state returns to IDLE.
- Accepted illegal request: no word emitted. err_valid=1 for exactly one cycle, starting the cycle after acceptance. err_code updated. out register untouched.
- Output stability: while out_valid & ~out_ready, out_word stays stable.
- words_emitted: increments on each out_valid & out_ready. Wraps from 2^CNT_W-1 to 0.
- Inputs are ignored when in_ready=0.

Test Plan:
- addi x1,x2,5 with out_ready=1 → out_word=0x00510093 one cycle after accept; words_emitted=1.
- srai x3,x4,7, out_ready held low 3 cycles → out_word=0x40725193 held stable; in_ready=0 during stall; count increments only at release.
- li: addi x5,x0,0x12345678 → 0x123452B7 then 0x67828293; in_ready=0 between the two words; count +2.
- addi x1,x0,0x800 → 0x000010B7, 0x80008093 (negative lo12 rounding).
- addi x1,x0,0x1000 → single word 0x000010B7.
- Errors:
  - slli imm=32 → err_valid pulse, err_code=11.
  - andi rs1=1 imm=4096 → err_code=10.
  - iak_invalid → err_code=01.
  - In all three cases out_valid stays 0.
- Reset asserted in PEND with out_ready=0 → next cycle out_valid=0, state IDLE, count 0; no ADDI emitted afterwards.

Source files
------------

// File: rtl/imm_arith_encoder.sv
// imm_arith_encoder
// Assembles RV32I OP-IMM instructions from a decoded operation kind plus
// rd/rs1/immediate and streams them out on a valid/ready interface.
// An "addi rd, x0, imm" whose immediate does not fit in 12 signed bits is
// expanded into LUI rd,hi20 followed by ADDI rd,rd,lo12. When lo12 is zero,
// only the LUI is emitted. Illegal requests produce no word; they raise a
// one-cycle error pulse and a sticky error code instead.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   in_valid/ready  request handshake
//   in_kind         operation (imm_arith_kind_t)
//   in_rd, in_rs1   register indices
//   in_imm          signed immediate or shift amount
//   out_valid/ready instruction word handshake
//   out_word        encoded instruction
//   err_valid       one-cycle pulse, last accepted request rejected
//   err_code        01 invalid kind, 10 imm out of range, 11 bad shamt
//   words_emitted   wrapping count of completed out handshakes

package imm_arith_encoder_pkg;
    typedef enum logic [3:0] {
        iak_addi,
        iak_slti,
        iak_sltiu,
        iak_xori,
        iak_ori,
        iak_andi,
        iak_slli,
        iak_srli,
        iak_srai,
        iak_invalid
    } imm_arith_kind_t;
endpackage

module imm_arith_encoder
    import imm_arith_encoder_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  imm_arith_kind_t      in_kind,
    input  logic [4:0]           in_rd,
    input  logic [4:0]           in_rs1,
    input  logic [31:0]          in_imm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_word,
    output logic                 err_valid,
    output logic [1:0]           err_code,
    output logic [CNT_W-1:0]     words_emitted
);

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    typedef enum logic {IDLE, PEND} state_t;

    state_t              state_q, state_d;
    logic                outValid_q, outValid_d;
    logic [31:0]         outWord_q, outWord_d;
    logic [31:0]         pendWord_q, pendWord_d;
    logic                errValid_q, errValid_d;
    logic [1:0]          errCode_q, errCode_d;
    logic [CNT_W-1:0]    count_q, count_d;

    logic [2:0]          funct3;
    logic [6:0]          funct7;
    logic                isShift;
    logic                kindValid;
    logic                immFits12;
    logic                shamtOk;
    logic                needExpand;
    logic [1:0]          reqErr;
    logic [31:0]         roundedImm;
    logic [31:0]         plainWord;
    logic [31:0]         luiWord;
    logic [31:0]         addiWord;
    logic                outFire;
    logic                accept;

    assign outFire  = outValid_q & out_ready;
    assign in_ready = (state_q == IDLE) & (~outValid_q | out_ready);
    assign accept   = in_valid & in_ready;

    // Map the operation kind onto its funct3/funct7 fields.
    always_comb begin
        funct3    = 3'b000;
        funct7    = 7'b0000000;
        isShift   = 1'b0;
        kindValid = 1'b1;
        case (in_kind)
            iak_addi:  funct3 = 3'b000;
            iak_slti:  funct3 = 3'b010;
            iak_sltiu: funct3 = 3'b011;
            iak_xori:  funct3 = 3'b100;
            iak_ori:   funct3 = 3'b110;
            iak_andi:  funct3 = 3'b111;
            iak_slli: begin
                funct3  = 3'b001;
                isShift = 1'b1;
            end
            iak_srli: begin
                funct3  = 3'b101;
                isShift = 1'b1;
            end
            iak_srai: begin
                funct3  = 3'b101;
                funct7  = 7'b0100000;
                isShift = 1'b1;
            end
            default: kindValid = 1'b0;
        endcase
    end

    // A value fits in 12 signed bits when bits 31..11 are all copies of the sign.
    assign immFits12  = (in_imm[31:11] == {21{in_imm[11]}});
    assign shamtOk    = (in_imm[31:5] == 27'd0);
    assign needExpand = (in_kind == iak_addi) && (in_rs1 == 5'd0) && !immFits12;

    // Invalid kind takes priority, then the shift and immediate range checks.
    always_comb begin
        reqErr = 2'b00;
        if (!kindValid)
            reqErr = 2'b01;
        else if (isShift && !shamtOk)
            reqErr = 2'b11;
        else if (!isShift && !immFits12 && !needExpand)
            reqErr = 2'b10;
    end

    // Adding 0x800 before taking the upper 20 bits compensates for the
    // sign-extended low 12 bits that the following ADDI will add back.
    assign roundedImm = in_imm + 32'h0000_0800;
    assign luiWord    = {roundedImm[31:12], in_rd, OPC_LUI};
    assign addiWord   = {in_imm[11:0], in_rd, 3'b000, in_rd, OPC_OP_IMM};
    assign plainWord  = isShift ? {funct7, in_imm[4:0], in_rs1, funct3, in_rd, OPC_OP_IMM}
                                : {in_imm[11:0], in_rs1, funct3, in_rd, OPC_OP_IMM};

    // Next-state logic: a new request can only be taken in IDLE when the
    // output slot is free or draining this cycle, so loading the output
    // here never overwrites an unconsumed word.
    always_comb begin
        state_d    = state_q;
        outValid_d = outValid_q & ~outFire;
        outWord_d  = outWord_q;
        pendWord_d = pendWord_q;
        errValid_d = 1'b0;
        errCode_d  = errCode_q;
        count_d    = count_q;
        if (outFire)
            count_d = count_q + CNT_W'(1);
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (reqErr != 2'b00) begin
                        errValid_d = 1'b1;
                        errCode_d  = reqErr;
                    end else if (needExpand) begin
                        outWord_d  = luiWord;
                        outValid_d = 1'b1;
                        pendWord_d = addiWord;
                        if (in_imm[11:0] != 12'd0)
                            state_d = PEND;
                    end else begin
                        outWord_d  = plainWord;
                        outValid_d = 1'b1;
                    end
                end
            end
            PEND: begin
                if (outFire) begin
                    outWord_d  = pendWord_q;
                    outValid_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset overrides any handshake this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            outValid_q <= 1'b0;
            outWord_q  <= 32'd0;
            pendWord_q <= 32'd0;
            errValid_q <= 1'b0;
            errCode_q  <= 2'b00;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            outValid_q <= outValid_d;
            outWord_q  <= outWord_d;
            pendWord_q <= pendWord_d;
            errValid_q <= errValid_d;
            errCode_q  <= errCode_d;
            count_q    <= count_d;
        end
    end

    assign out_valid     = outValid_q;
    assign out_word      = outWord_q;
    assign err_valid     = errValid_q;
    assign err_code      = errCode_q;
    assign words_emitted = count_q;

endmodule
